// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNTW_DEF  = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply (mode=0) or restoring divide (mode=1).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  // The shifted remainder needs WIDTH+1 bits because it can exceed the divisor width.
  always_comb begin
    sum       = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand})
                       : {1'b0, acc[2*WIDTH-1:WIDTH]};
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    diff      = rem_shift[WIDTH-1:0] - operand;
    acc_next  = {sum, acc[WIDTH-1:1]};
    if (mode) begin
      if (rem_shift >= {1'b0, operand}) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding HI/LO, with the PC stall for early reads.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_read,
  output logic             stall,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0,
  output logic [1:0]       state_dbg
);

  state_e             state;
  logic [CNTW-1:0]    cnt;
  logic               is_div_q;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic               b_zero_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] fix_val;

  op_e              op_in;
  logic             sgn_op;
  logic             div_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_v;
  logic [WIDTH-1:0] quot_v;

  assign op_in     = op_e'(op);
  assign state_dbg = state;

  // Handshake: start is a request held by the PC; it is taken only in IDLE (busy=0).
  // While busy, a start or hilo_read raises stall and the same instruction is re-presented.
  assign stall = busy & (hilo_read | start);

  always_comb begin
    sgn_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    div_op = (op_in == OP_DIV) || (op_in == OP_DIVU);
    a_mag  = (sgn_op && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
    b_mag  = (sgn_op && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand_q),
    .mode     (is_div_q),
    .acc_next (acc_next)
  );

  // Divide-by-zero overrides the natural restoring result so HI keeps the original dividend.
  always_comb begin
    rem_v   = acc[2*WIDTH-1:WIDTH];
    quot_v  = acc[WIDTH-1:0];
    fix_val = neg_quot_q ? (~acc + 1'b1) : acc;
    if (is_div_q) begin
      if (b_zero_q) begin
        fix_val = {dividend_q, {WIDTH{1'b1}}};
      end else begin
        fix_val = {(neg_rem_q ? (~rem_v + 1'b1) : rem_v),
                   (neg_quot_q ? (~quot_v + 1'b1) : quot_v)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_div_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      dividend_q <= '0;
      operand_q  <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      hilo_we    <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      div0       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div_q   <= div_op;
            neg_quot_q <= sgn_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_rem_q  <= sgn_op && srca[WIDTH-1];
            b_zero_q   <= (srcb == '0);
            dividend_q <= srca;
            if (div_op) begin
              operand_q <= b_mag;
              acc       <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              operand_q <= a_mag;
              acc       <= {{WIDTH{1'b0}}, b_mag};
            end
            cnt   <= '0;
            div0  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          acc     <= fix_val;
          hilo_we <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          hi      <= acc[2*WIDTH-1:WIDTH];
          lo      <= acc[WIDTH-1:0];
          div0    <= is_div_q && b_zero_q;
          hilo_we <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
